// File: rtl/multi_note_gate_timer_if.sv
// Key/gate bundle for multi_note_gate_timer.
// Master drives keys and hold length; slave returns gates and levels.
interface multi_note_gate_timer_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 21,
  parameter int LEVEL_W  = 4
);
  logic [CHANNELS-1:0]         iKey;
  logic [CNT_W-1:0]            iHoldTicks;
  logic [CHANNELS-1:0]         oRing;
  logic                        oActive;
  logic [CHANNELS*LEVEL_W-1:0] oLevel;

  modport master (
    output iKey,
    output iHoldTicks,
    input  oRing,
    input  oActive,
    input  oLevel
  );

  modport slave (
    input  iKey,
    input  iHoldTicks,
    output oRing,
    output oActive,
    output oLevel
  );
endinterface

// File: rtl/multi_note_gate_timer.sv
// Per-key note gate timers sharing one sustain tick prescaler.
// Define NOTE_FADE_EN to make oLevel fade during sustain.
module multi_note_gate_timer #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 21,
  parameter int TICK_DIV = 1000,
  parameter int LEVEL_W  = 4
) (
  input logic                  iClk,
  input logic                  iReset_n,
  multi_note_gate_timer_if.slave bus
);

  localparam int PRE_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    SUSTAIN = 2'd2
  } stateT;

  logic [PRE_W-1:0]    preQ;
  logic                tick;

  stateT               stateQ [CHANNELS];
  stateT               stateD [CHANNELS];
  logic [CNT_W-1:0]    cntQ   [CHANNELS];
  logic [CNT_W-1:0]    cntD   [CHANNELS];
  logic [CNT_W-1:0]    holdQ  [CHANNELS];
  logic [CNT_W-1:0]    holdD  [CHANNELS];
  logic [CHANNELS-1:0] ringQ;
  logic [CHANNELS-1:0] ringD;

  assign tick = (preQ == PRE_MAX);

  // Free-running prescaler, tick on its last count.
  always_ff @(posedge iClk) begin
    if (!iReset_n)
      preQ <= '0;
    else if (tick)
      preQ <= '0;
    else
      preQ <= preQ + 1'b1;
  end

  // Per-channel gate state machine next-state logic.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      stateD[c] = stateQ[c];
      cntD[c]   = cntQ[c];
      holdD[c]  = holdQ[c];
      unique case (stateQ[c])
        IDLE: begin
          if (bus.iKey[c])
            stateD[c] = HELD;
        end
        HELD: begin
          cntD[c] = '0;
          if (!bus.iKey[c]) begin
            stateD[c] = SUSTAIN;
            holdD[c]  = bus.iHoldTicks;
          end
        end
        SUSTAIN: begin
          if (bus.iKey[c]) begin
            stateD[c] = HELD;
            cntD[c]   = '0;
          end else if (holdQ[c] == '0) begin
            stateD[c] = IDLE;
            cntD[c]   = '0;
          end else if (tick) begin
            if ((cntQ[c] + 1'b1) == holdQ[c]) begin
              stateD[c] = IDLE;
              cntD[c]   = '0;
            end else begin
              cntD[c] = cntQ[c] + 1'b1;
            end
          end
        end
        default: begin
          stateD[c] = IDLE;
          cntD[c]   = '0;
        end
      endcase
      ringD[c] = (stateD[c] != IDLE);
    end
  end

  // Channel state, counters, latched hold and gate registers.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        stateQ[c] <= IDLE;
        cntQ[c]   <= '0;
        holdQ[c]  <= '0;
      end
      ringQ <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        stateQ[c] <= stateD[c];
        cntQ[c]   <= cntD[c];
        holdQ[c]  <= holdD[c];
      end
      ringQ <= ringD;
    end
  end

  assign bus.oRing   = ringQ;
  assign bus.oActive = |ringQ;

`ifdef NOTE_FADE_EN
  logic [LEVEL_W-1:0] lvlQ [CHANNELS];
  logic [LEVEL_W-1:0] lvlD [CHANNELS];

  // Level follows the next state; fades one step per sustain tick.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      lvlD[c] = lvlQ[c];
      unique case (stateD[c])
        IDLE: lvlD[c] = '0;
        HELD: lvlD[c] = '1;
        SUSTAIN: begin
          if (stateQ[c] == SUSTAIN && tick &&
              lvlQ[c] > LEVEL_W'(1))
            lvlD[c] = lvlQ[c] - 1'b1;
        end
        default: lvlD[c] = '0;
      endcase
    end
  end

  // Level registers.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        lvlQ[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        lvlQ[c] <= lvlD[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : gLvl
    assign bus.oLevel[c*LEVEL_W +: LEVEL_W] = lvlQ[c];
  end
`else
  for (genvar c = 0; c < CHANNELS; c++) begin : gLvl
    assign bus.oLevel[c*LEVEL_W +: LEVEL_W] =
      {LEVEL_W{ringQ[c]}};
  end
`endif

endmodule
